// File: rtl/fibo_seq_engine.sv
// Fibonacci/Lucas-style sequence generator. It holds the term registers, adder, term
// counter and control FSM, and streams terms over a valid/ready handshake.
module fibo_seq_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic             stop_on_ovf,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic [CNT_W-1:0] n_terms,
   input  logic             term_ready,
   output logic             term_valid,
   output logic [WIDTH-1:0] term,
   output logic [CNT_W-1:0] term_idx,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EMIT   = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_aw;
   logic             r_bw;
   logic [CNT_W-1:0] r_k;
   logic [CNT_W-1:0] r_idx;
   logic             r_stop;
   logic             r_ovf;

   logic [WIDTH:0]   w_sum;
   logic             w_suppress;

   assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
   assign w_suppress = r_aw & r_stop;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_aw    <= 1'b0;
         r_bw    <= 1'b0;
         r_k     <= '0;
         r_idx   <= '0;
         r_stop  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= mode ? seed_a : '0;
                  r_b     <= mode ? seed_b : WIDTH'(1);
                  r_aw    <= 1'b0;
                  r_bw    <= 1'b0;
                  r_k     <= n_terms;
                  r_idx   <= '0;
                  r_stop  <= stop_on_ovf;
                  r_ovf   <= 1'b0;
                  r_state <= (n_terms == '0) ? S_DONE : S_EMIT;
               end
            end
            S_EMIT: begin
               if (w_suppress) begin
                  r_state <= S_DONE;
               end else if (term_ready) begin
                  if (r_k == CNT_W'(1)) begin
                     r_state <= S_DONE;
                  end else begin
                     r_k     <= r_k - CNT_W'(1);
                     r_idx   <= r_idx + CNT_W'(1);
                     r_state <= S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               // The flag moving into A is recorded as overflow here, so it is
               // already visible in the EMIT cycle that presents (or suppresses) it.
               r_a     <= r_b;
               r_aw    <= r_bw;
               r_b     <= w_sum[WIDTH-1:0];
               r_bw    <= w_sum[WIDTH] | r_aw | r_bw;
               r_ovf   <= r_ovf | r_bw;
               r_state <= S_EMIT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign term_valid = (r_state == S_EMIT) & ~w_suppress;
   assign term       = r_a;
   assign term_idx   = r_idx;
   assign busy       = (r_state == S_EMIT) | (r_state == S_UPDATE);
   assign done       = (r_state == S_DONE);
   assign overflow   = r_ovf;

endmodule

// File: doc/fibo_seq_engine.md
# fibo_seq_engine

Self-sequencing, parametrised Fibonacci/Lucas-style sequence generator. It combines the sequence registers, adder, term counter and control FSM in one block. It streams successive terms over a valid/ready handshake, with wrap-around or stop-on-overflow policy. It sits after the fixed 4-bit datapath-plus-external-controller arrangement and replaces it wherever a sequence source is needed.

## Interface
- WIDTH, 8, term width in bits (≥2)
- CNT_W, 8, width of term count and term index
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- start  input  1  request a new run; accepted only in IDLE
- mode  input  1  0: seeds 0,1; 1: seeds from seed_a, seed_b
- stop_on_ovf  input  1  1: end run before first wrapped term; 0: emit wrapped terms
- seed_a  input  WIDTH  first term when mode=1
- seed_b  input  WIDTH  second term when mode=1
- n_terms  input  CNT_W  number of terms to emit (0 allowed)
- term_ready  input  1  consumer accepts term this cycle
- term_valid  output  1  term/term_idx valid
- term  output  WIDTH  current term value
- term_idx  output  CNT_W  index of current term, 0-based
- busy  output  1  run in progress
- done  output  1  one-cycle end-of-run pulse
- overflow  output  1  sticky; set when any emitted or suppressed term wrapped

## Operation
- Internal state: A, B (WIDTH), wrap flags aw, bw, K (remaining terms, CNT_W), idx (CNT_W), FSM {IDLE, EMIT, UPDATE, DONE}.
- IDLE: busy=0, term_valid=0. On start:
  - load A/B = mode ? seed_a/seed_b : 0/1; aw=bw=0; K=n_terms; idx=0; overflow cleared.
  - next state is DONE if n_terms==0, else EMIT.
  - mode, seeds, stop_on_ovf and n_terms are captured at start. Later changes are ignored; stop_on_ovf is latched.
- EMIT: busy=1.
  - If aw=1 and latched stop_on_ovf=1: term_valid=0, overflow set, next DONE. The wrapped term is never presented.
  - Otherwise term_valid=1, term=A, term_idx=idx.
  - If aw=1, overflow is set when the term is first presented.
  - term_valid is held with term stable until term_ready=1.
  - On transfer (valid&ready): if K==1, next DONE; else K←K−1, idx←idx+1, next UPDATE.
- UPDATE: busy=1, term_valid=0.
  - A←B, aw←bw, {c,B}←A+B (WIDTH+1-bit add, keep low WIDTH bits), bw←c|aw|bw.
  - Next state EMIT.
- DONE: done=1 for exactly one cycle, busy=0, next IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. A wrapped term stays flagged, and all later terms are flagged.
- start is ignored in EMIT/UPDATE/DONE; it is not queued.
- Rst_n=0 in any state aborts the run on that edge. The next state is IDLE.

## Timing
- Reset values: term_valid=0, term=0, term_idx=0, busy=0, done=0, overflow=0; A=B=K=idx=0, FSM=IDLE.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Start accepted at edge t: the first term is valid in cycle t+1.
- With term_ready held high, term k is valid in cycle t+1+2k, giving 1 term per 2 cycles.
- Last transfer at cycle u: done=1 in cycle u+1, IDLE at u+2. The earliest next start is accepted at edge u+2.
- n_terms=0: done=1 in cycle t+1, with no term_valid.
- Stop-on-overflow: done follows the suppressing EMIT cycle by one cycle.
- Backpressure: each cycle with term_valid=1 and term_ready=0 adds one cycle of latency. term and term_idx must not change during it.
- n_terms=2^CNT_W−1 must run to completion; idx never wraps within a run.

## Test plan
- Reset, then mode=0, n_terms=10, ready=1 → terms 0,1,1,2,3,5,8,13,21,34 at 2-cycle spacing, idx 0..9, done 1 cycle after last, overflow=0.
- WIDTH=8, mode=0, n_terms=16, stop_on_ovf=0 → term 13 = 233, term 14 = 121 (377 mod 256), term 15 = 98; overflow rises with term 14 and stays 1.
- Same run with stop_on_ovf=1 → 14 terms (0..233), no idx-14 term, done pulse, overflow=1.
- mode=1, seed_a=2, seed_b=1, n_terms=6, with term_ready low for 3 cycles on term 2 → Lucas terms 2,1,3,4,7,11; term 2 holds value 3 while stalled; no term lost or duplicated.
- n_terms=0 → done=1 in cycle after start, no term_valid; start pulsed during busy has no effect.
- Rst_n=0 mid-run after term 4 → next cycle all outputs 0, IDLE; a new start gives a fresh sequence from idx 0.
